// File: rtl/rd53_fitness_ctrl.sv
// Fitness evaluator: sweeps all 32 rd53 input vectors through a candidate circuit and counts
// output-bit mismatches against the golden weight-based model, LAT cycles later.
module rd53_fitness_ctrl #(
    parameter int unsigned LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [4:0] cand_pi,
    output logic       cand_valid,
    input  logic [2:0] cand_po,
    output logic       busy,
    output logic       done,
    output logic [6:0] fitness,
    output logic       perfect
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [2:0] drain_q, drain_d;
    logic [6:0] acc_q, acc_d;
    logic [6:0] fitness_q, fitness_d;
    logic       perfect_q, perfect_d;
    logic       done_q, done_d;
    logic       cand_valid_q, cand_valid_d;
    logic       busy_q, busy_d;

    logic       flush;
    logic       dly_vld;
    logic [2:0] dly_gold;
    logic [2:0] err_bits;
    logic [6:0] err_cnt;

    // po0 = (w >= 4), po1 = w[1], po2 = w[0], where w is the vector weight
    function automatic logic [2:0] golden(input logic [4:0] v);
        logic [2:0] w;
        w = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]);
        return {w[0], w[1], (w >= 3'd4)};
    endfunction

    assign flush = abort && (state_q == StRun || state_q == StDrain);

    generate
        if (LAT == 0) begin : g_no_pipe
            assign dly_vld  = cand_valid_q;
            assign dly_gold = golden(cnt_q);
        end else begin : g_pipe
            logic [LAT-1:0]      pvld_q, pvld_d;
            logic [LAT-1:0][2:0] pgold_q, pgold_d;

            always_comb begin
                pvld_d     = '0;
                pgold_d    = '0;
                pvld_d[0]  = cand_valid_q && !flush;
                pgold_d[0] = golden(cnt_q);
                for (int i = 1; i < int'(LAT); i++) begin
                    pvld_d[i]  = pvld_q[i-1] && !flush;
                    pgold_d[i] = pgold_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pvld_q  <= '0;
                    pgold_q <= '0;
                end else begin
                    pvld_q  <= pvld_d;
                    pgold_q <= pgold_d;
                end
            end

            assign dly_vld  = pvld_q[LAT-1];
            assign dly_gold = pgold_q[LAT-1];
        end
    endgenerate

    assign err_bits = cand_po ^ dly_gold;
    assign err_cnt  = 7'(err_bits[0]) + 7'(err_bits[1]) + 7'(err_bits[2]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        fitness_d = fitness_q;
        perfect_d = perfect_q;

        if (dly_vld && !flush) begin
            acc_d = acc_q + err_cnt;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == 5'd31) begin
                    cnt_d = '0;
                    if (LAT > 0) begin
                        state_d = StDrain;
                        drain_d = 3'(LAT - 1);
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (drain_q == 3'd0) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            StDone: begin
                state_d   = StIdle;
                done_d    = 1'b1;
                fitness_d = acc_q;
                perfect_d = (acc_q == 7'd0);
            end
            default: state_d = StIdle;
        endcase

        cand_valid_d = (state_d == StRun);
        busy_d       = (state_d == StRun) || (state_d == StDrain);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            drain_q      <= '0;
            acc_q        <= '0;
            fitness_q    <= '0;
            perfect_q    <= 1'b0;
            done_q       <= 1'b0;
            cand_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            acc_q        <= acc_d;
            fitness_q    <= fitness_d;
            perfect_q    <= perfect_d;
            done_q       <= done_d;
            cand_valid_q <= cand_valid_d;
            busy_q       <= busy_d;
        end
    end

    // cnt_q is held at zero outside RUN, so it doubles as the vector bus
    assign cand_pi    = cnt_q;
    assign cand_valid = cand_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fitness    = fitness_q;
    assign perfect    = perfect_q;

endmodule
